// File: rtl/spi_reg_bridge_pkg.sv
// spi_reg_bridge_pkg: shared state encoding, command field layout and
// the default filler reply byte for the SPI register bridge.
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DRAIN
    } state_t;

    localparam int         CMD_WRITE_BIT       = 7;
    localparam int         ADDR_W              = 7;
    localparam logic [7:0] STATUS_BYTE_DEFAULT = 8'hA5;

    // Command byte: bit 7 selects write, low bits carry the start address.
    function automatic logic cmd_is_write(input logic [7:0] b);
        return b[CMD_WRITE_BIT];
    endfunction

    function automatic logic [ADDR_W-1:0] cmd_addr(input logic [7:0] b);
        return b[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/spi_sync2.sv
// spi_sync2: two-flop synchroniser for the raw slave-select line.
// Resets to 1 so the bridge starts out treating the bus as idle.
module spi_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage resync of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            dout <= 1'b1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: byte command engine behind spi_slave. Decodes a command
// header, then performs writes or prefetched reads on a 128 x 8 register bus
// and feeds reply bytes back through send_data.
// Build option: SPI_REG_BRIDGE_BURST_EN enables auto-increment bursts; without
// it each frame carries exactly one data byte and then drains until ss rises.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DEFAULT
) (
    input  logic              ext_clk,
    input  logic              rst,
    input  logic              ss,
    input  logic [7:0]        recv_data,
    input  logic              recv_ready,
    input  logic              send_ready,
    output logic [7:0]        send_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [7:0]        reg_rdata,
    output logic              busy
);

    state_t            state, state_n;
    logic              ss_idle;
    logic [7:0]        pend, pend_n;
    logic [7:0]        tx_hold;
    logic [ADDR_W-1:0] addr, addr_n;      // next address a data byte will use
    logic [ADDR_W-1:0] reg_addr_n;
    logic [7:0]        reg_wdata_n;
    logic              reg_we_n, reg_re_n;
    logic              rd_pend, rd_pend_n; // reg_rdata is valid this cycle

    spi_sync2 u_ss_sync (
        .clk   (ext_clk),
        .rst_n (rst),
        .din   (ss),
        .dout  (ss_idle)
    );

    assign busy = ~ss_idle;

    // spi_slave may sample at any time; outside send_ready it must see a
    // stable byte, so it gets the last value it was offered.
    assign send_data = send_ready ? pend : tx_hold;

    // Next-state and next register-bus values.
    always_comb begin
        state_n     = state;
        pend_n      = pend;
        addr_n      = addr;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;
        rd_pend_n   = 1'b0;
        if (ss_idle) begin
            // Frame boundary wins over any byte arriving in the same cycle.
            state_n = IDLE;
            pend_n  = STATUS_BYTE;
        end else begin
            rd_pend_n = reg_re;
            if (rd_pend)
                pend_n = reg_rdata;
            case (state)
                IDLE: state_n = CMD;
                CMD: begin
                    if (recv_ready) begin
                        if (cmd_is_write(recv_data)) begin
                            state_n = WRITE;
                            addr_n  = cmd_addr(recv_data);
                        end else begin
                            // Prefetch the first read byte right away so it is
                            // ready in time for the reply slot two bytes later.
                            state_n    = READ;
                            reg_re_n   = 1'b1;
                            reg_addr_n = cmd_addr(recv_data);
                            addr_n     = cmd_addr(recv_data) + 7'd1;
                        end
                    end
                end
                WRITE: begin
                    if (recv_ready) begin
                        reg_we_n    = 1'b1;
                        reg_addr_n  = addr;
                        reg_wdata_n = recv_data;
                        pend_n      = recv_data;
                        addr_n      = addr + 7'd1;
`ifndef SPI_REG_BRIDGE_BURST_EN
                        state_n     = DRAIN;
`endif
                    end
                end
                READ: begin
                    // Received bytes are dummies; each one advances the prefetch.
                    if (recv_ready) begin
`ifdef SPI_REG_BRIDGE_BURST_EN
                        reg_re_n   = 1'b1;
                        reg_addr_n = addr;
                        addr_n     = addr + 7'd1;
`else
                        state_n    = DRAIN;
`endif
                    end
                end
                DRAIN: state_n = DRAIN;
                default: state_n = IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge ext_clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Registered bus strobes, reply byte and address tracking.
    always_ff @(posedge ext_clk or negedge rst) begin
        if (!rst) begin
            pend      <= STATUS_BYTE;
            tx_hold   <= STATUS_BYTE;
            addr      <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            pend      <= pend_n;
            tx_hold   <= send_data;
            addr      <= addr_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
            rd_pend   <= rd_pend_n;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb_spi_reg_bridge: directed bench for spi_reg_bridge with a behavioural
// 128 x 8 register file and an spi_slave-like reply sampler.
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_BURST_EN
    localparam int BURST = 1;
`else
    localparam int BURST = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss = 1'b1;
    logic [7:0] recv_data = 8'h00;
    logic       recv_ready = 1'b0;
    logic       send_ready = 1'b0;
    logic [7:0] send_data;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    logic [7:0] mem [0:127];
    logic [7:0] reply_q[$];
    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];

    spi_reg_bridge dut (
        .ext_clk    (clk),
        .rst        (rst_n),
        .ss         (ss),
        .recv_data  (recv_data),
        .recv_ready (recv_ready),
        .send_ready (send_ready),
        .send_data  (send_data),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Register file: write on strobe, read data valid the cycle after reg_re.
    always @(posedge clk) begin
        if (reg_we) mem[reg_addr] <= reg_wdata;
        if (reg_re) reg_rdata <= mem[reg_addr];
    end

    // Log strobes and sampled reply bytes away from the active edge.
    always @(negedge clk) begin
        if (reg_we) begin
            we_addr_q.push_back({1'b0, reg_addr});
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back({1'b0, reg_addr});
        if (reg_we && reg_re) both_cnt++;
        if (send_ready) reply_q.push_back(send_data);
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       is_wr;
        logic [7:0] exp_addr;
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] qget(input logic [7:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 8'hxx;
    endfunction

    task automatic clear_logs();
        reply_q.delete();
        we_addr_q.delete();
        we_data_q.delete();
        re_addr_q.delete();
    endtask

    task automatic frame_begin();
        clear_logs();
        @(posedge clk); #1 ss = 1'b0;
        repeat (6) @(posedge clk);
        #1 send_ready = 1'b1;
        @(posedge clk); #1 send_ready = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    // Byte at T, reply sample pulse at T+2, then idle spacing.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 recv_data = b; recv_ready = 1'b1;
        @(posedge clk); #1 recv_ready = 1'b0;
        @(posedge clk); #1 send_ready = 1'b1;
        @(posedge clk); #1 send_ready = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic frame_end();
        @(posedge clk); #1 ss = 1'b1;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[7'h7E] = 8'hC1;
        mem[7'h7F] = 8'hC2;
        mem[7'h00] = 8'hC3;

        vecs[0] = '{8'h85, 8'h11, 1'b1, 8'h05, 8'h11};
        vecs[1] = '{8'hFD, 8'h3C, 1'b1, 8'h7D, 8'h3C};
        vecs[2] = '{8'hC0, 8'h5E, 1'b1, 8'h40, 8'h5E};
        vecs[3] = '{8'h05, 8'h00, 1'b0, 8'h05, 8'h11};
        vecs[4] = '{8'h7D, 8'h00, 1'b0, 8'h7D, 8'h3C};
        vecs[5] = '{8'h10, 8'h00, 1'b0, 8'h10, 8'h4A};
        vecs[6] = '{8'h40, 8'h00, 1'b0, 8'h40, 8'h5E};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst send_data", {24'h0, send_data}, 32'hA5);
        check("rst reg_we", {31'h0, reg_we}, 32'h0);
        check("rst reg_re", {31'h0, reg_re}, 32'h0);
        check("rst busy", {31'h0, busy}, 32'h0);
        check("rst reg_addr", {25'h0, reg_addr}, 32'h0);
        check("rst reg_wdata", {24'h0, reg_wdata}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Single-data-byte frames from the table
        for (int v = 0; v < 7; v++) begin
            frame_begin();
            send_byte(vecs[v].cmd);
            send_byte(vecs[v].data);
            frame_end();
            check($sformatf("v%0d reply0", v), {24'h0, qget(reply_q, 0)}, 32'hA5);
            check($sformatf("v%0d reply1", v), {24'h0, qget(reply_q, 1)}, 32'hA5);
            check($sformatf("v%0d reply2", v), {24'h0, qget(reply_q, 2)}, {24'h0, vecs[v].exp_val});
            if (vecs[v].is_wr) begin
                check($sformatf("v%0d we count", v), we_addr_q.size(), 32'd1);
                check($sformatf("v%0d we addr", v), {24'h0, qget(we_addr_q, 0)}, {24'h0, vecs[v].exp_addr});
                check($sformatf("v%0d we data", v), {24'h0, qget(we_data_q, 0)}, {24'h0, vecs[v].exp_val});
                check($sformatf("v%0d re count", v), re_addr_q.size(), 32'd0);
            end else begin
                check($sformatf("v%0d re count", v), re_addr_q.size(), BURST ? 32'd2 : 32'd1);
                check($sformatf("v%0d re addr", v), {24'h0, qget(re_addr_q, 0)}, {24'h0, vecs[v].exp_addr});
                check($sformatf("v%0d we count", v), we_addr_q.size(), 32'd0);
            end
        end

`ifdef SPI_REG_BRIDGE_BURST_EN
        // Burst write with echo
        frame_begin();
        send_byte(8'h85); send_byte(8'h11); send_byte(8'h22);
        frame_end();
        check("bw we count", we_addr_q.size(), 32'd2);
        check("bw we0 addr", {24'h0, qget(we_addr_q, 0)}, 32'h05);
        check("bw we0 data", {24'h0, qget(we_data_q, 0)}, 32'h11);
        check("bw we1 addr", {24'h0, qget(we_addr_q, 1)}, 32'h06);
        check("bw we1 data", {24'h0, qget(we_data_q, 1)}, 32'h22);
        check("bw reply0", {24'h0, qget(reply_q, 0)}, 32'hA5);
        check("bw reply1", {24'h0, qget(reply_q, 1)}, 32'hA5);
        check("bw reply2", {24'h0, qget(reply_q, 2)}, 32'h11);

        // Burst read across the 7F -> 00 wrap
        frame_begin();
        send_byte(8'h7E);
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        frame_end();
        check("br reply0", {24'h0, qget(reply_q, 0)}, 32'hA5);
        check("br reply1", {24'h0, qget(reply_q, 1)}, 32'hA5);
        check("br reply2", {24'h0, qget(reply_q, 2)}, 32'hC1);
        check("br reply3", {24'h0, qget(reply_q, 3)}, 32'hC2);
        check("br reply4", {24'h0, qget(reply_q, 4)}, 32'hC3);
        check("br re0", {24'h0, qget(re_addr_q, 0)}, 32'h7E);
        check("br re1", {24'h0, qget(re_addr_q, 1)}, 32'h7F);
        check("br re2", {24'h0, qget(re_addr_q, 2)}, 32'h00);
        check("br re3", {24'h0, qget(re_addr_q, 3)}, 32'h01);
`else
        // One data byte per frame; the rest drain
        frame_begin();
        send_byte(8'h83); send_byte(8'h44); send_byte(8'h55);
        frame_end();
        check("nb we count", we_addr_q.size(), 32'd1);
        check("nb we addr", {24'h0, qget(we_addr_q, 0)}, 32'h03);
        check("nb we data", {24'h0, qget(we_data_q, 0)}, 32'h44);
        check("nb reply2", {24'h0, qget(reply_q, 2)}, 32'h44);
        check("nb reply3 hold", {24'h0, qget(reply_q, 3)}, 32'h44);

        // Read repeats data[A] after the first data slot
        frame_begin();
        send_byte(8'h7E);
        for (int k = 0; k < 3; k++) send_byte(8'h00);
        frame_end();
        check("nr reply1", {24'h0, qget(reply_q, 1)}, 32'hA5);
        check("nr reply2", {24'h0, qget(reply_q, 2)}, 32'hC1);
        check("nr reply3", {24'h0, qget(reply_q, 3)}, 32'hC1);
        check("nr reply4", {24'h0, qget(reply_q, 4)}, 32'hC1);
        check("nr re count", re_addr_q.size(), 32'd1);
        check("nr re addr", {24'h0, qget(re_addr_q, 0)}, 32'h7E);
`endif

        // Abort a read mid-frame, then a fresh frame decodes cleanly
        frame_begin();
        send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        @(posedge clk); #1 ss = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("abort busy", {31'h0, busy}, 32'h0);
        repeat (8) @(posedge clk);
        check("abort re count", re_addr_q.size(), BURST ? 32'd3 : 32'd1);
        #1 send_ready = 1'b1;
        @(negedge clk);
        check("abort send_data", {24'h0, send_data}, 32'hA5);
        @(posedge clk); #1 send_ready = 1'b0;
        @(negedge clk);
        check("abort hold", {24'h0, send_data}, 32'hA5);
        frame_begin();
        send_byte(8'h81); send_byte(8'h77);
        frame_end();
        check("fresh we count", we_addr_q.size(), 32'd1);
        check("fresh we addr", {24'h0, qget(we_addr_q, 0)}, 32'h01);
        check("fresh we data", {24'h0, qget(we_data_q, 0)}, 32'h77);
        check("fresh reply2", {24'h0, qget(reply_q, 2)}, 32'h77);

        // Byte arriving in the first ss_idle cycle is dropped
        frame_begin();
        send_byte(8'h90);
        @(posedge clk); #1 ss = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 recv_data = 8'h99; recv_ready = 1'b1;
        @(posedge clk); #1 recv_ready = 1'b0;
        repeat (6) @(posedge clk);
        check("late byte we count", we_addr_q.size(), 32'd0);
        check("late byte busy", {31'h0, busy}, 32'h0);

        check("we/re overlap", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Byte-level command engine sitting directly downstream of `spi_slave`, in the `ext_clk` domain. Consumes received bytes (`recv_data`/`recv_ready`), decodes a one-byte command header, and performs burst writes or prefetched burst reads on a 128-entry 8-bit register bus. Feeds reply bytes back to `spi_slave` on `send_data`, honouring its `send_ready` stability rule.

## Interface
- `STATUS_BYTE`, default 8'hA5: filler reply byte sent before read data and at frame start.
- `ext_clk  input  1  system clock, ≥16× SCLK`
- `rst  input  1  reset, asynchronous, active-low`
- `ss  input  1  raw SPI slave-select (active-low), synchronised internally`
- `recv_data  input  8  byte from spi_slave`
- `recv_ready  input  1  one-cycle pulse: recv_data valid`
- `send_ready  input  1  spi_slave may sample send_data`
- `send_data  output  8  next reply byte to spi_slave`
- `reg_addr  output  7  register address`
- `reg_wdata  output  8  write data`
- `reg_we  output  1  one-cycle write strobe`
- `reg_re  output  1  one-cycle read strobe`
- `reg_rdata  input  8  read data, valid exactly 1 cycle after reg_re`
- `busy  output  1  frame active (synchronised ss low)`

## Operation
- `ss` passes through a 2-flop synchroniser → `ss_idle`. `ss_idle` high forces state IDLE, `pend <= STATUS_BYTE`, and clears pending prefetch; a recv_ready in the same cycle is ignored.
- Command byte: bit7 = 1 write / 0 read; bits[6:0] = start address A.
- States: IDLE →(ss_idle low) CMD →(recv_ready, bit7=1) WRITE / (bit7=0) READ; WRITE/READ →(ss_idle) IDLE. DRAIN exists only with burst disabled.
- WRITE: each data byte → `reg_we`, `reg_addr`=current address, `reg_wdata`=byte; `pend <= byte` (echo, one-byte lag); address increments.
- READ: on entry, prefetch A (`reg_re`); `reg_rdata` → `pend`. On each subsequent recv_ready, address increments and next prefetch issues. Bytes received in READ are discarded.
- Reply sequence, read frame: byte0 STATUS, byte1 STATUS, byte2 data[A], byte3 data[A+1], … Last prefetch reads one address beyond the last byte shifted; register side effects must tolerate this.
- Address arithmetic 7-bit, wraps 7'h7F → 7'h00.
- `send_data = send_ready ? pend : tx_hold`; `tx_hold <= send_data` every cycle. `pend` changes only while `send_ready` low and ≥2 cycles before the next pulse.
- Reset values: state IDLE, `pend`/`tx_hold` = STATUS_BYTE (so `send_data` = STATUS_BYTE), `reg_addr` 0, `reg_wdata` 0, `reg_we` 0, `reg_re` 0, `busy` 0. Reset mid-frame aborts with no further strobes.

## Timing
- recv_ready at cycle T → `reg_we` or `reg_re` asserted in T+1 (registered, one cycle, with `reg_addr`).
- Read: `reg_re` T+1, `reg_rdata` sampled end of T+2, `pend` valid T+3.
- Minimum recv_ready spacing required: 4 cycles (guaranteed at 16× SCLK, ≈128 cycles/byte).
- `ss` to `busy`/state change: 2–3 cycles.
- Never `reg_we` and `reg_re` in the same cycle.

## Configuration
- `SPI_REG_BRIDGE_BURST_EN` defined: auto-increment, unlimited bytes per frame as above.
- Undefined: exactly one data byte per frame; after it, state DRAIN (no strobes, no address increment, `pend` holds) until `ss_idle`. Read returns data[A] in byte2, then repeats it.

## Structure
- Package `spi_reg_bridge_pkg`: state enum (IDLE, CMD, WRITE, READ, DRAIN), command field constants (write bit 7, address [6:0]), default STATUS_BYTE.
- Sub-module `spi_sync2`: 2-flop synchroniser for `ss`, reset-to-1 (idle).

## Test plan
- Reset, `ss` high → `send_data`=8'hA5, all strobes 0, `busy` 0.
- Frame {8'h85, 8'h11, 8'h22} → `reg_we` at addr 5 data 8'h11, addr 6 data 8'h22; replies A5, A5, 11.
- Regs 7E=8'hC1, 7F=8'hC2, 00=8'hC3; frame {8'h7E, xx, xx, xx, xx} → replies A5, A5, C1, C2, C3; `reg_re` addresses 7E,7F,00,01 (wrap).
- `ss` raised mid-read after byte2 → IDLE within 3 cycles, `send_data`=A5, no further `reg_re`; next frame decodes fresh command.
- recv_ready coincident with first cycle of `ss_idle` → byte ignored, no strobe.
- Burst macro undefined: frame {8'h83, 8'h44, 8'h55} → single `reg_we` addr 3 data 8'h44, none for 8'h55.
